exu_lsu: RTL and testbench
==========================

# exu_lsu

Parametrised load/store unit for the execute stage. It is the sequential successor to the combinational memory-control decode. It accepts one memory operation at a time from the EXU over a valid/ready handshake and issues a single aligned request to the data-memory port. It handles byte-lane placement, write masks, sign/zero extension, misalignment detection and response timeout, and returns one result to writeback per accepted operation.

## Interface
Parameters:
- `XLEN`, 32: data and address width; 32 or 64.
- `TIMEOUT`, 255: maximum cycles spent waiting for a load response; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `in_load` in 1: operation is a load.
- `in_store` in 1: operation is a store.
- `in_size` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = dword.
- `in_unsigned` in 1: zero-extend the load result (lbu/lhu/lwu); otherwise sign-extend.
- `in_addr` in XLEN: effective address (ALU result).
- `in_wdata` in XLEN: store data (src2), right-justified.
- `mem_req_valid` out 1: memory request pending.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_we` out 1: request is a write.
- `mem_addr` out XLEN: `in_addr` with the low log2(XLEN/8) bits cleared.
- `mem_wdata` out XLEN: store data shifted into its byte lanes.
- `mem_wmask` out XLEN/8: byte-enable mask.
- `mem_resp_valid` in 1: read data valid.
- `mem_rdata` in XLEN: aligned read word.
- `out_valid` out 1: one-cycle completion pulse.
- `out_rdata` out XLEN: extended load data; 0 for stores, non-memory operations and errors.
- `out_err` out 1: misaligned access, illegal size, or timeout; valid with `out_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Acceptance: an operation is accepted when `in_valid && in_ready`. All inputs are latched on acceptance, so the inputs may change afterwards.
- Byte count and offset: bytes = 1 << `in_size`. off = `in_addr[log2(XLEN/8)-1:0]`.
- Error conditions; any of these sends IDLE → DONE with `out_err` = 1 and issues no memory request:
  - `in_load` and `in_store` both high;
  - off mod bytes ≠ 0 (misaligned);
  - `in_size` = 3 with XLEN = 32.
- Non-memory operation: neither `in_load` nor `in_store` set → IDLE → DONE with `out_err` = 0 and `out_rdata` = 0.
- Otherwise IDLE → REQ.
- Store lanes:
  - `mem_wdata` = (`in_wdata` masked to its low bytes) << (8·off).
  - `mem_wmask` = ((1 << bytes) − 1) << off.
  - `mem_we` = 1.
- Load request: `mem_we` = 0 and `mem_wmask` = all ones.
- REQ: `mem_req_valid` = 1, with `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` held stable until `mem_req_ready`. On the handshake:
  - a store goes to DONE (writes are posted);
  - a load goes to WAIT and clears the timeout counter.
- WAIT:
  - `mem_resp_valid` → capture the data and go to DONE.
  - Load data: `mem_rdata` >> (8·off), truncated to bytes and sign- or zero-extended to XLEN per `in_unsigned`.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT with no response → DONE with `out_err` = 1 and `out_rdata` = 0. A response arriving in the same cycle as the counter reaching TIMEOUT wins.
- DONE: `out_valid` = 1 for exactly one cycle, then IDLE. There is no output backpressure; writeback always takes the result.
- `mem_resp_valid` outside WAIT is ignored.
- The counter is ceil(log2(TIMEOUT+1)) bits wide and saturates.

## Timing
- Reset (`rst` sampled high): state = IDLE. Every output is driven to 0 except `in_ready`, which is 1 in the cycle after reset. Any in-flight operation is dropped with no `out_valid`. A response that arrives after a reset is ignored.
- `mem_req_valid` must never drop before `mem_req_ready` is seen.
- Latency, counted from acceptance at cycle T:
  - error or non-memory: `out_valid` at T+1;
  - store with `mem_req_ready` already high: `out_valid` at T+2;
  - load with ready high and response one cycle after the request: `out_valid` at T+3.
- Each cycle of `mem_req_ready` low or of response delay adds exactly one cycle.
- Throughput: one operation in flight. `in_ready` rises again in the cycle after DONE.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Test plan
- Store half, XLEN = 32: `in_addr` 0x80000006, `in_wdata` 0x1234ABCD → `mem_addr` 0x80000004, `mem_wmask` 4'b1100, `mem_wdata` 0xABCD0000, `out_valid` at T+2 with `out_err` = 0.
- Load byte: `in_addr` 0x80000003, `mem_rdata` 0x80FF7F01 → `out_rdata` 0xFFFFFF80; the same load with `in_unsigned` = 1 → 0x00000080.
- Misaligned word load at 0x80000002 → `mem_req_valid` stays 0; `out_valid` and `out_err` are both 1 at T+1.
- `mem_req_ready` held low for 3 cycles on a word store → request fields stable throughout, `in_ready` = 0, `out_valid` at T+5.
- TIMEOUT = 4 with no response → `out_err` = 1 with `out_rdata` = 0. Repeat with the response arriving on the 4th WAIT cycle → data returned and `out_err` = 0.
- Reset asserted in WAIT, then `mem_resp_valid` pulses → no `out_valid`; the next accepted load completes normally. XLEN = 64 dword load at 0x...8 → full 64-bit data.

Source files
------------

// File: rtl/exu_lsu.sv
// Load/store unit for the execute stage: one memory operation in flight, aligned
// data-memory request, byte-lane placement, load extension, misalignment and timeout errors.
module exu_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OW  = $clog2(NB);
  localparam int unsigned CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [OW-1:0] off_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  logic [OW-1:0]   in_off;
  logic [OW-1:0]   align_mask;
  logic            is_mem;
  logic            acc_err;
  logic [XLEN-1:0] st_wdata;
  logic [NB-1:0]   st_wmask;

  function automatic logic [NB-1:0] lane_mask(input logic [OW-1:0] off, input logic [1:0] sz);
    int unsigned lo;
    int unsigned n;
    logic [NB-1:0] m;
    lo = 32'(off);
    n  = 32'd1 << sz;
    m  = '0;
    for (int unsigned j = 0; j < NB; j++) m[j] = (j >= lo) && (j < lo + n);
    return m;
  endfunction

  function automatic logic [XLEN-1:0] place_store(input logic [XLEN-1:0] wd,
                                                  input logic [OW-1:0] off,
                                                  input logic [1:0] sz);
    logic [XLEN-1:0] keep;
    int unsigned nbits;
    nbits = 32'd8 << sz;
    for (int unsigned i = 0; i < XLEN; i++) keep[i] = (i < nbits) ? wd[i] : 1'b0;
    return keep << {off, 3'b000};
  endfunction

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rd,
                                                  input logic [OW-1:0] off,
                                                  input logic [1:0] sz,
                                                  input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    logic sb;
    int unsigned nbits;
    sh    = rd >> {off, 3'b000};
    nbits = 32'd8 << sz;
    case (sz)
      2'd0:    sb = sh[7];
      2'd1:    sb = sh[15];
      2'd2:    sb = sh[31];
      default: sb = sh[XLEN-1];
    endcase
    sb = sb & ~uns;
    for (int unsigned i = 0; i < XLEN; i++) res[i] = (i < nbits) ? sh[i] : sb;
    return res;
  endfunction

  assign in_ready      = (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign out_valid     = (state == S_DONE);
  assign in_off        = in_addr[OW-1:0];
  assign cnt_inc       = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    align_mask = '0;
    case (in_size)
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OW'(1);
      2'd2:    align_mask = OW'(3);
      default: align_mask = OW'(7);
    endcase
    is_mem   = in_load | in_store;
    // Alignment and size only matter for real memory ops; a load+store combination is always an error.
    acc_err  = (in_load && in_store) ||
               (is_mem && (((in_off & align_mask) != '0) || ((in_size == 2'd3) && (XLEN == 32))));
    st_wdata = place_store(in_wdata, in_off, in_size);
    st_wmask = lane_mask(in_off, in_size);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            off_q     <= in_off;
            size_q    <= in_size;
            uns_q     <= in_unsigned;
            out_rdata <= '0;
            out_err   <= acc_err;
            if (acc_err || !is_mem) begin
              state <= S_DONE;
            end else begin
              mem_addr  <= {in_addr[XLEN-1:OW], {OW{1'b0}}};
              mem_we    <= in_store;
              mem_wdata <= in_store ? st_wdata : '0;
              mem_wmask <= in_store ? st_wmask : '1;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= mem_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          // A response coinciding with the timeout threshold takes priority.
          if (mem_resp_valid) begin
            out_rdata <= extend_load(mem_rdata, off_q, size_q, uns_q);
            out_err   <= 1'b0;
            state     <= S_DONE;
          end else if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
            out_rdata <= '0;
            out_err   <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu: XLEN=32 and XLEN=64 instances, both with TIMEOUT=4; result
// scoreboards fed at issue time and drained by out_valid monitors.
module tb_exu_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit DUT
  logic        in_valid = 0, in_load = 0, in_store = 0, in_unsigned = 0;
  logic [1:0]  in_size = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        in_ready, mem_req_valid, mem_we, out_valid, out_err;
  logic        mem_req_ready = 1, mem_resp_valid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, out_rdata;
  logic [3:0]  mem_wmask;

  exu_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err)
  );

  // 64-bit DUT
  logic        d_in_valid = 0, d_in_load = 0, d_in_store = 0, d_in_unsigned = 0;
  logic [1:0]  d_in_size = 0;
  logic [63:0] d_in_addr = 0, d_in_wdata = 0;
  logic        d_in_ready, d_mem_req_valid, d_mem_we, d_out_valid, d_out_err;
  logic        d_mem_req_ready = 1, d_mem_resp_valid = 0;
  logic [63:0] d_mem_addr, d_mem_wdata, d_mem_rdata = 0, d_out_rdata;
  logic [7:0]  d_mem_wmask;

  exu_lsu #(.XLEN(64), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_load(d_in_load), .in_store(d_in_store), .in_size(d_in_size), .in_unsigned(d_in_unsigned),
    .in_addr(d_in_addr), .in_wdata(d_in_wdata),
    .mem_req_valid(d_mem_req_valid), .mem_req_ready(d_mem_req_ready), .mem_we(d_mem_we),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_wmask(d_mem_wmask),
    .mem_resp_valid(d_mem_resp_valid), .mem_rdata(d_mem_rdata),
    .out_valid(d_out_valid), .out_rdata(d_out_rdata), .out_err(d_out_err)
  );

  logic [32:0] q32[$];
  logic [64:0] q64[$];

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL sb32_unexpected out_valid got rdata=%h err=%b, no result expected", out_rdata, out_err);
      end else begin
        logic [32:0] e;
        e = q32.pop_front();
        if ({out_rdata, out_err} !== e)
          begin errors++; $display("FAIL sb32 got rdata=%h err=%b expected rdata=%h err=%b", out_rdata, out_err, e[32:1], e[0]); end
      end
    end
    if (d_out_valid) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL sb64_unexpected out_valid got rdata=%h err=%b", d_out_rdata, d_out_err);
      end else begin
        logic [64:0] e;
        e = q64.pop_front();
        if ({d_out_rdata, d_out_err} !== e)
          begin errors++; $display("FAIL sb64 got rdata=%h err=%b expected rdata=%h err=%b", d_out_rdata, d_out_err, e[64:1], e[0]); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Enter at #1 after a rising edge with the 32-bit DUT idle; returns likewise.
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_lo, input int resp_after, input logic [31:0] rd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic exp_req, input logic [31:0] exp_maddr,
                        input logic [31:0] exp_mwdata, input logic [3:0] exp_mwmask);
    int lat = 1, lo_cnt = 0, wcnt = 0;
    bit req_seen = 0, hs_done = 0, waiting = 0, done = 0, hs;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b expected 1", nm, in_ready); end
    in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_wdata = wd;
    mem_req_ready = (rdy_lo == 0);
    q32.push_back({exp_rd, exp_err});
    @(posedge clk); #1;
    in_valid = 0; in_load = $urandom; in_store = $urandom; in_size = $urandom;
    in_unsigned = $urandom; in_addr = $urandom; in_wdata = $urandom;
    while (!done) begin
      if (req_seen && !hs_done) begin
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s req_dropped got %b expected 1", nm, mem_req_valid); end
      end
      if (out_valid) begin
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d expected %0d", nm, lat, exp_lat); end
        done = 1;
      end else if (lat >= 40) begin
        checks++; errors++;
        $display("FAIL %s completion got none after %0d cycles expected at %0d", nm, lat, exp_lat);
        done = 1;
      end else begin
        hs = 0;
        if (mem_req_valid) begin
          req_seen = 1;
          checks++;
          if ({mem_addr, mem_we, mem_wmask, in_ready} !== {exp_maddr, st, exp_mwmask, 1'b0}) begin
            errors++;
            $display("FAIL %s req_fields got addr=%h we=%b mask=%b ready=%b expected addr=%h we=%b mask=%b ready=0",
                     nm, mem_addr, mem_we, mem_wmask, in_ready, exp_maddr, st, exp_mwmask);
          end
          if (st) begin
            checks++;
            if (mem_wdata !== exp_mwdata) begin errors++; $display("FAIL %s wdata got %h expected %h", nm, mem_wdata, exp_mwdata); end
          end
          if (lo_cnt < rdy_lo) begin mem_req_ready = 0; lo_cnt++; end
          else mem_req_ready = 1;
          hs = mem_req_ready;
        end
        if (waiting) begin
          mem_resp_valid = (resp_after >= 0) && (wcnt == resp_after);
          mem_rdata = mem_resp_valid ? rd : $urandom;
          wcnt++;
        end else begin
          // Stray response outside WAIT must be ignored.
          mem_resp_valid = mem_req_valid;
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        lat++;
        if (hs) begin hs_done = 1; if (ld) waiting = 1; end
      end
    end
    mem_resp_valid = 0; mem_req_ready = 1;
    checks++;
    if (req_seen != exp_req) begin errors++; $display("FAIL %s req_issued got %b expected %b", nm, req_seen, exp_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_rdata, out_err}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b we=%b addr=%h wd=%h mask=%b ov=%b rd=%h err=%b expected ready=1 rest 0",
               in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_rdata, out_err);
    end
    checks++;
    if ({d_in_ready, d_mem_req_valid, d_out_valid, d_out_rdata} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_outputs64 got ready=%b rv=%b ov=%b rd=%h expected 1/0/0/0", d_in_ready, d_mem_req_valid, d_out_valid, d_out_rdata);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    run_op("sh_lanes", 0, 1, 2'd1, 0, 32'h80000006, 32'h1234ABCD, 0, -1, 0,
           32'h0, 0, 2, 1, 32'h80000004, 32'hABCD0000, 4'b1100);
    run_op("sb_lane1", 0, 1, 2'd0, 0, 32'h80000001, 32'hFFFFFF5A, 0, -1, 0,
           32'h0, 0, 2, 1, 32'h80000000, 32'h00005A00, 4'b0010);
    run_op("sw_stall", 0, 1, 2'd2, 0, 32'h80000010, 32'hDEADBEEF, 3, -1, 0,
           32'h0, 0, 5, 1, 32'h80000010, 32'hDEADBEEF, 4'b1111);
  endtask

  task automatic test_load;
    run_op("lb_sign", 1, 0, 2'd0, 0, 32'h80000003, 0, 0, 0, 32'h80FF7F01,
           32'hFFFFFF80, 0, 3, 1, 32'h80000000, 0, 4'hF);
    run_op("lbu_zero", 1, 0, 2'd0, 1, 32'h80000003, 0, 0, 0, 32'h80FF7F01,
           32'h00000080, 0, 3, 1, 32'h80000000, 0, 4'hF);
    run_op("lh_sign", 1, 0, 2'd1, 0, 32'h80000002, 0, 0, 0, 32'h80017FFF,
           32'hFFFF8001, 0, 3, 1, 32'h80000000, 0, 4'hF);
    run_op("lhu_low", 1, 0, 2'd1, 1, 32'h80000000, 0, 0, 0, 32'h80017FFF,
           32'h00007FFF, 0, 3, 1, 32'h80000000, 0, 4'hF);
    run_op("lbu_delays", 1, 0, 2'd0, 1, 32'h80000101, 0, 2, 1, 32'h0000C300,
           32'h000000C3, 0, 6, 1, 32'h80000100, 0, 4'hF);
  endtask

  task automatic test_errors;
    run_op("lw_misaligned", 1, 0, 2'd2, 0, 32'h80000002, 0, 0, 0, 0,
           32'h0, 1, 1, 0, 0, 0, 0);
    run_op("sh_misaligned", 0, 1, 2'd1, 0, 32'h80000001, 32'h5555, 0, 0, 0,
           32'h0, 1, 1, 0, 0, 0, 0);
    run_op("dword_on_32", 1, 0, 2'd3, 0, 32'h80000000, 0, 0, 0, 0,
           32'h0, 1, 1, 0, 0, 0, 0);
    run_op("load_and_store", 1, 1, 2'd2, 0, 32'h80000000, 0, 0, 0, 0,
           32'h0, 1, 1, 0, 0, 0, 0);
    run_op("non_memory", 0, 0, 2'd2, 0, 32'h80000003, 32'hFFFF, 0, 0, 0,
           32'h0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_timeout;
    run_op("lw_timeout", 1, 0, 2'd2, 0, 32'h80000020, 0, 0, -1, 0,
           32'h0, 1, 6, 1, 32'h80000020, 0, 4'hF);
    run_op("lw_resp_at_limit", 1, 0, 2'd2, 0, 32'h80000020, 0, 0, 3, 32'h13579BDF,
           32'h13579BDF, 0, 6, 1, 32'h80000020, 0, 4'hF);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_load", 1, 0, 2'd2, 0, 32'h80000030, 0, 0, 0, 32'hCAFEF00D,
           32'hCAFEF00D, 0, 3, 1, 32'h80000030, 0, 4'hF);
    run_op("b2b_store", 0, 1, 2'd0, 0, 32'h80000033, 32'h000000A5, 0, -1, 0,
           32'h0, 0, 2, 1, 32'h80000030, 32'hA5000000, 4'b1000);
  endtask

  task automatic test_reset_in_wait;
    in_valid = 1; in_load = 1; in_store = 0; in_size = 2'd2; in_unsigned = 0;
    in_addr = 32'h80000040; mem_req_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({in_ready, mem_req_valid, out_valid, out_err, out_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wait_reset_state got ready=%b rv=%b ov=%b err=%b rd=%h expected 1/0/0/0/0",
               in_ready, mem_req_valid, out_valid, out_err, out_rdata);
    end
    mem_resp_valid = 1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL late_resp out_valid got %b expected 0", out_valid); end
      @(posedge clk); #1;
    end
    run_op("load_after_reset", 1, 0, 2'd2, 0, 32'h80000044, 0, 0, 0, 32'h0BADF00D,
           32'h0BADF00D, 0, 3, 1, 32'h80000044, 0, 4'hF);
  endtask

  task automatic test_xlen64;
    logic [63:0] addrs[3] = '{64'h0000_0000_8000_0008, 64'h0000_0000_8000_000C, 64'h0000_0000_8000_000C};
    logic [1:0]  sizes[3] = '{2'd3, 2'd2, 2'd2};
    logic        unss[3]  = '{1'b0, 1'b0, 1'b1};
    logic [63:0] rds[3]   = '{64'h8877665544332211, 64'hF1234567_89ABCDEF, 64'hF1234567_89ABCDEF};
    logic [63:0] exps[3]  = '{64'h8877665544332211, 64'hFFFFFFFF_F1234567, 64'h00000000_F1234567};
    for (int k = 0; k < 3; k++) begin
      d_in_valid = 1; d_in_load = 1; d_in_store = 0; d_in_size = sizes[k];
      d_in_unsigned = unss[k]; d_in_addr = addrs[k]; d_mem_req_ready = 1;
      q64.push_back({exps[k], 1'b0});
      @(posedge clk); #1;
      d_in_valid = 0; d_in_addr = $urandom;
      checks++;
      if ({d_mem_req_valid, d_mem_we, d_mem_addr, d_mem_wmask} !== {1'b1, 1'b0, 64'h0000_0000_8000_0008, 8'hFF}) begin
        errors++;
        $display("FAIL x64_req[%0d] got rv=%b we=%b addr=%h mask=%b expected 1/0/%h/11111111",
                 k, d_mem_req_valid, d_mem_we, d_mem_addr, d_mem_wmask, 64'h0000_0000_8000_0008);
      end
      @(posedge clk); #1;
      d_mem_resp_valid = 1; d_mem_rdata = rds[k];
      @(posedge clk); #1;
      d_mem_resp_valid = 0;
      checks++;
      if (d_out_valid !== 1'b1) begin errors++; $display("FAIL x64_latency[%0d] out_valid got %b expected 1", k, d_out_valid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_errors;
    test_timeout;
    test_back_to_back;
    test_reset_in_wait;
    test_xlen64;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q32.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d pending expected 0/0", q32.size(), q64.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
